seq_divider: RTL and testbench

Sequential unsigned restoring divider. It is the inverse counterpart of the shift-add multiplier: operands are accepted on a start handshake, one quotient bit is resolved per clock, and a done pulse accompanies registered quotient and remainder. The control FSM and the shift/subtract datapath are contained in one block that sits beside the multiplier in the arithmetic unit.

---
 rtl/div_pkg.sv | 18 +
 rtl/div_ctrl_fsm.sv | 78 +++++++
 rtl/seq_divider.sv | 105 ++++++++++
 tb/tb_seq_divider.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: state encoding,
// default operand width and iteration counter sizing.
package div_pkg;

    localparam int unsigned DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_e;

    // Counter must reach WIDTH-1 and carry one spare bit for headroom
    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/div_ctrl_fsm.sv
// Divider controller: sequences IDLE -> CALC (WIDTH steps) -> FIN and issues
// load / shift-subtract / finish strobes to the datapath.
module div_ctrl_fsm
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic div_zero_c,
    output logic ld_c,
    output logic shsub_c,
    output logic fin_c,
    output logic busy,
    output logic done
);

    localparam int unsigned CNT_W = cnt_width(WIDTH);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            count_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // fin_c marks the edge entering FIN, when the datapath captures results
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        ld_c    = 1'b0;
        shsub_c = 1'b0;
        fin_c   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    ld_c    = 1'b1;
                    count_d = '0;
                    if (div_zero_c) begin
                        state_d = FIN;
                        fin_c   = 1'b1;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                shsub_c = 1'b1;
                count_d = count_q + CNT_W'(1);
                if (count_q == CNT_W'(WIDTH - 1)) begin
                    state_d = FIN;
                    fin_c   = 1'b1;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == FIN);
    end

    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock, results
// registered on entry to FIN and held until the next completion.
module seq_divider
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned AW = WIDTH + 1;

    logic             ld_c, shsub_c, fin_c, div_zero_c;
    logic [AW-1:0]    a_q, a_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dz_q, dz_d;
    logic [AW:0]      t_a;
    logic [WIDTH-1:0] t_q;
    logic             ge;

    assign div_zero_c = (divisor == '0);

    div_ctrl_fsm #(.WIDTH(WIDTH)) u_ctrl (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .div_zero_c (div_zero_c),
        .ld_c       (ld_c),
        .shsub_c    (shsub_c),
        .fin_c      (fin_c),
        .busy       (busy),
        .done       (done)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_q    <= '0;
            q_q    <= '0;
            d_q    <= '0;
            quot_q <= '0;
            rem_q  <= '0;
            dz_q   <= 1'b0;
        end else begin
            a_q    <= a_d;
            q_q    <= q_d;
            d_q    <= d_d;
            quot_q <= quot_d;
            rem_q  <= rem_d;
            dz_q   <= dz_d;
        end
    end

    // Shift {A,Q} left one place; the extra top bit keeps the compare exact
    assign t_a = {a_q, q_q[WIDTH-1]};
    assign t_q = {q_q[WIDTH-2:0], 1'b0};
    assign ge  = (t_a >= {2'b00, d_q});

    always_comb begin
        a_d    = a_q;
        q_d    = q_q;
        d_d    = d_q;
        quot_d = quot_q;
        rem_d  = rem_q;
        dz_d   = dz_q;
        if (ld_c) begin
            a_d = '0;
            q_d = dividend;
            d_d = divisor;
            if (div_zero_c) begin
                quot_d = '1;
                rem_d  = dividend;
                dz_d   = 1'b1;
            end
        end else if (shsub_c) begin
            if (ge) begin
                a_d = AW'(t_a - {2'b00, d_q});
            end else begin
                a_d = AW'(t_a);
            end
            q_d = {t_q[WIDTH-1:1], ge};
            if (fin_c) begin
                quot_d = q_d;
                rem_d  = a_d[WIDTH-1:0];
                dz_d   = 1'b0;
            end
        end
    end

    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: vector table, multi-cycle corner
// sequences and a randomised sweep against an arithmetic reference model.
module tb_seq_divider;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] dividend, divisor;
    logic         busy, done, div_by_zero;
    logic [W-1:0] quotient, remainder;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] prev_q, prev_r;
    logic         prev_dz;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        int           lat;
    } vec_t;

    vec_t vecs[8];

    seq_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_q"},    32'(quotient), 0);
        chk({tag, "_r"},    32'(remainder), 0);
        chk({tag, "_dz"},   32'(div_by_zero), 0);
    endtask

    // Issue one operation and check results, latency and hold behaviour
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] eq, er;
        logic         edz;
        int           elat, n;
        if (b == 0) begin
            eq = {W{1'b1}}; er = a; edz = 1'b1; elat = 1;
        end else begin
            eq = W'(a / b); er = W'(a % b); edz = 1'b0; elat = W + 1;
        end
        n = 0;
        while (busy && n < 40) begin
            tick;
            n++;
        end
        if (busy) chk("idle_wait", 32'(busy), 0);
        start = 1'b1; dividend = a; divisor = b;
        tick;
        start = 1'b0;
        dividend = W'($urandom); divisor = W'($urandom);
        n = 1;
        while (!done && n < 40) begin
            chk("busy_calc", 32'(busy), 1);
            chk("hold_q", 32'(quotient), 32'(prev_q));
            chk("hold_r", 32'(remainder), 32'(prev_r));
            tick;
            n++;
        end
        chk("latency", n, elat);
        chk("busy_fin", 32'(busy), 1);
        chk("quotient", 32'(quotient), 32'(eq));
        chk("remainder", 32'(remainder), 32'(er));
        chk("div_by_zero", 32'(div_by_zero), 32'(edz));
        prev_q = eq; prev_r = er; prev_dz = edz;
        tick;
        chk("done_pulse", 32'(done), 0);
        chk("busy_after", 32'(busy), 0);
        chk("q_held", 32'(quotient), 32'(eq));
    endtask

    initial begin
        int dcnt;
        logic [W-1:0] cq, cr;
        int done_at[$];

        vecs[0] = '{a:8'd100, b:8'd7,   q:8'd14,  r:8'd2,  dz:1'b0, lat:9};
        vecs[1] = '{a:8'd255, b:8'd1,   q:8'd255, r:8'd0,  dz:1'b0, lat:9};
        vecs[2] = '{a:8'd5,   b:8'd9,   q:8'd0,   r:8'd5,  dz:1'b0, lat:9};
        vecs[3] = '{a:8'd255, b:8'd255, q:8'd1,   r:8'd0,  dz:1'b0, lat:9};
        vecs[4] = '{a:8'd37,  b:8'd0,   q:8'hFF,  r:8'd37, dz:1'b1, lat:1};
        vecs[5] = '{a:8'd20,  b:8'd4,   q:8'd5,   r:8'd0,  dz:1'b0, lat:9};
        vecs[6] = '{a:8'd0,   b:8'd0,   q:8'hFF,  r:8'd0,  dz:1'b1, lat:1};
        vecs[7] = '{a:8'd200, b:8'd3,   q:8'd66,  r:8'd2,  dz:1'b0, lat:9};

        reset = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
        prev_q = '0; prev_r = '0; prev_dz = 1'b0;
        #12;
        chk_reset_vals("rst_init");
        @(negedge clk);
        reset = 1'b1;
        tick; tick;
        chk_reset_vals("rst_idle");

        // Table vectors: result, latency and the done pulse
        for (int i = 0; i < 8; i++) begin
            int n;
            start = 1'b1; dividend = vecs[i].a; divisor = vecs[i].b;
            tick;
            start = 1'b0;
            n = 1;
            while (!done && n < 40) begin
                tick;
                n++;
            end
            chk("tbl_latency", n, vecs[i].lat);
            chk("tbl_q", 32'(quotient), 32'(vecs[i].q));
            chk("tbl_r", 32'(remainder), 32'(vecs[i].r));
            chk("tbl_dz", 32'(div_by_zero), 32'(vecs[i].dz));
            prev_q = vecs[i].q; prev_r = vecs[i].r; prev_dz = vecs[i].dz;
            tick;
            chk("tbl_done_low", 32'(done), 0);
        end

        run_op(8'd100, 8'd7);
        run_op(8'd37, 8'd0);
        run_op(8'd20, 8'd4);

        // start with new operands while busy must be ignored
        dcnt = 0; cq = '0; cr = '0;
        start = 1'b1; dividend = 8'd100; divisor = 8'd7;
        tick;
        start = 1'b0;
        for (int i = 2; i <= 20; i++) begin
            if (i == 4) begin
                start = 1'b1; dividend = 8'd9; divisor = 8'd3;
            end
            if (i == 8) start = 1'b0;
            tick;
            if (done) begin
                dcnt++; cq = quotient; cr = remainder;
            end else if (i < 9) begin
                chk("busy_hold_q", 32'(quotient), 32'(prev_q));
            end
        end
        chk("busy_start_dones", dcnt, 1);
        chk("busy_start_q", 32'(cq), 14);
        chk("busy_start_r", 32'(cr), 2);
        prev_q = 8'd14; prev_r = 8'd2; prev_dz = 1'b0;

        // start held high: one completion every WIDTH+2 cycles
        start = 1'b1; dividend = 8'd100; divisor = 8'd7;
        for (int i = 1; i <= 35; i++) begin
            tick;
            if (done) done_at.push_back(i);
        end
        start = 1'b0;
        chk("b2b_count", done_at.size(), 3);
        if (done_at.size() == 3) begin
            chk("b2b_first", done_at[0], W + 1);
            chk("b2b_gap1", done_at[1] - done_at[0], W + 2);
            chk("b2b_gap2", done_at[2] - done_at[1], W + 2);
        end
        run_op(8'd20, 8'd4);

        // Reset mid-operation, asserted away from any clock edge
        start = 1'b1; dividend = 8'd200; divisor = 8'd3;
        tick;
        start = 1'b0;
        tick; tick; tick; tick;
        chk("pre_reset_busy", 32'(busy), 1);
        #2 reset = 1'b0;
        #1 chk_reset_vals("rst_async");
        tick; tick;
        chk_reset_vals("rst_held");
        reset = 1'b1;
        prev_q = '0; prev_r = '0; prev_dz = 1'b0;
        dcnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick;
            if (done) dcnt++;
        end
        chk("rst_no_done", dcnt, 0);
        run_op(8'd200, 8'd3);

        // Randomised sweep against plain arithmetic
        for (int i = 0; i < 1000; i++) begin
            logic [W-1:0] a, b;
            a = W'($urandom);
            b = W'($urandom_range(1, 255));
            run_op(a, b);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
